// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared types and constants for the processor scheduler
package processor_pkg;

  // Arbiter states; encoding is visible on debug taps, so it is pinned here.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_PIPE_DEPTH = 3;

  // Per-beat side information carried alongside the shared pipeline.
  typedef struct packed {
    logic valid;
    logic last;
    logic source;
  } shadow_t;

endpackage

// File: rtl/processor_valid_shadow.sv
// rtl/processor_valid_shadow.sv - enable-gated shift register of per-beat flags
module processor_valid_shadow
  import processor_pkg::*;
#(
  parameter int DEPTH = DEFAULT_PIPE_DEPTH
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] stage_in,
  output logic [2:0] stage_out
);

  shadow_t stages [DEPTH];

  // Shift in lockstep with the shared pipeline; reset wipes every stage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else if (enable) begin
      stages[0] <= stage_in;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign stage_out = stages[DEPTH-1];

endmodule

// File: rtl/processor_scheduler.sv
// rtl/processor_scheduler.sv - packet round-robin sharing one fixed-latency pipeline
module processor_scheduler
  import processor_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PIPE_DEPTH = DEFAULT_PIPE_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_valid,
  input  logic                  s0_last,
  output logic                  s0_ready,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_valid,
  input  logic                  s1_last,
  output logic                  s1_ready,
  output logic                  pipe_reset,
  output logic                  pipe_enable,
  output logic [DATA_WIDTH-1:0] pipe_in_data,
  output logic                  pipe_in_valid,
  output logic                  pipe_in_last,
  input  logic [DATA_WIDTH-1:0] pipe_out_data,
  input  logic                  pipe_out_valid,
  input  logic                  pipe_out_last,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  output logic                  m_source,
  input  logic                  m_ready
);

  arb_state_t state, state_next;
  logic       last_grant, last_grant_next;
  logic       grant0, grant1;
  logic       accept0, accept1;
  shadow_t    shadow_in, shadow_tail;

  // The pipeline's own valid/last are untrusted; the shadow supplies them.
  logic unused_pipe_flags;
  assign unused_pipe_flags = pipe_out_valid ^ pipe_out_last;

  assign pipe_reset  = ~reset;
  assign m_data      = pipe_out_data;
  assign m_valid     = shadow_tail.valid;
  assign m_last      = shadow_tail.valid & shadow_tail.last;
  assign m_source    = shadow_tail.source;
  assign pipe_enable = ~(m_valid & ~m_ready);

  // Grant selection, ready generation and packet-boundary state transitions.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    grant0          = 1'b0;
    grant1          = 1'b0;
    case (state)
      IDLE: begin
        if (s0_valid && (!s1_valid || last_grant == SRC1)) begin
          grant0 = 1'b1;
        end else if (s1_valid) begin
          grant1 = 1'b1;
        end
      end
      BUSY0:   grant0 = 1'b1;
      BUSY1:   grant1 = 1'b1;
      default: state_next = IDLE;
    endcase
    s0_ready = reset & pipe_enable & grant0;
    s1_ready = reset & pipe_enable & grant1;
    accept0  = s0_valid & s0_ready;
    accept1  = s1_valid & s1_ready;
    if (accept0) begin
      if (s0_last) begin
        state_next      = IDLE;
        last_grant_next = SRC0;
      end else begin
        state_next = BUSY0;
      end
    end else if (accept1) begin
      if (s1_last) begin
        state_next      = IDLE;
        last_grant_next = SRC1;
      end else begin
        state_next = BUSY1;
      end
    end
  end

  // Arbiter state; after reset source 1 counts as last served so source 0 wins a tie.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= SRC1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Pipeline input mux: the accepted beat, or an all-zero bubble.
  always_comb begin
    pipe_in_data  = '0;
    pipe_in_last  = 1'b0;
    pipe_in_valid = accept0 | accept1;
    if (accept0) begin
      pipe_in_data = s0_data;
      pipe_in_last = s0_last;
    end else if (accept1) begin
      pipe_in_data = s1_data;
      pipe_in_last = s1_last;
    end
  end

  assign shadow_in.valid  = pipe_in_valid;
  assign shadow_in.last   = pipe_in_last;
  assign shadow_in.source = accept1 ? SRC1 : SRC0;

  processor_valid_shadow #(
    .DEPTH(PIPE_DEPTH)
  ) u_shadow (
    .clock    (clock),
    .reset    (reset),
    .enable   (pipe_enable),
    .stage_in (shadow_in),
    .stage_out(shadow_tail)
  );

endmodule

// File: doc/processor_scheduler.md
# processor_scheduler

Packet-level round-robin scheduler that shares one fixed-latency example-processor pipeline between two 8-bit streaming sources. It grants the pipeline to one source per packet and never interleaves beats of different packets. It drives the pipeline's input and `enable`, and tracks beat validity and source ID in a shadow pipeline, because the shared pipeline's own valid output is unreliable. It applies sink backpressure by stalling the pipeline.

## Interface
- `DATA_WIDTH`, 8, stream data width.
- `PIPE_DEPTH`, 3, register stages in the shared pipeline (input-to-output latency in enabled cycles).
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-low (0 = reset).
- `s0_data` / `s1_data`  in  DATA_WIDTH  source beat data.
- `s0_valid` / `s1_valid`  in  1  source beat present.
- `s0_last` / `s1_last`  in  1  final beat of the source packet.
- `s0_ready` / `s1_ready`  out  1  beat accepted this cycle when valid && ready.
- `pipe_reset`  out  1  active-high reset to the pipeline, equal to `~reset`.
- `pipe_enable`  out  1  pipeline advance.
- `pipe_in_data`  out  DATA_WIDTH  beat into the pipeline; 0 for a bubble.
- `pipe_in_valid`  out  1  1 only for an accepted beat.
- `pipe_in_last`  out  1  last flag of the accepted beat; 0 for a bubble.
- `pipe_out_data`  in  DATA_WIDTH  pipeline result.
- `pipe_out_valid`  in  1  ignored; pipeline valid is not trusted.
- `pipe_out_last`  in  1  ignored; last is taken from the shadow.
- `m_data`  out  DATA_WIDTH  equal to `pipe_out_data`.
- `m_valid`  out  1  shadow valid at the tail stage.
- `m_last`  out  1  shadow last at the tail stage, gated by `m_valid`.
- `m_source`  out  1  source ID of the tail beat.
- `m_ready`  in  1  sink accepts the beat.

## Operation
Stall rule:
- `pipe_enable = ~(m_valid & ~m_ready)`.
- A beat is accepted only when `pipe_enable` = 1 and its source is granted.
- When `pipe_enable` = 1 and no beat is accepted, a bubble enters (valid 0).

Shadow pipeline:
- PIPE_DEPTH stages of {valid, last, source}.
- Shifts only when `pipe_enable` = 1, in lockstep with the pipeline.
- Stage 0 loads the accepted beat's flags, or zeros for a bubble.

Arbiter FSM, states IDLE, BUSY0, BUSY1:
- IDLE:
  - If exactly one source is valid, that source is granted.
  - If both are valid, the source ≠ `last_grant` is granted.
  - Grant and acceptance of the first beat happen in the same cycle.
  - If the accepted beat has last = 1: stay in IDLE and set `last_grant` = that source.
  - Otherwise go to BUSYx.
  - With no valid source, or `pipe_enable` = 0, the state is unchanged and nothing is accepted.
- BUSYx:
  - Only `sx_ready` may be 1; the other source's ready is held at 0.
  - A gap in `sx_valid` inserts bubbles and keeps the state.
  - An accepted beat with last = 1 moves to IDLE and sets `last_grant` = x.
- Ready outputs are combinational from state, the valid inputs, `last_grant` and `pipe_enable`.

## Timing
- Latency: a beat accepted in cycle t appears on `m_*` in cycle t+PIPE_DEPTH when there are no stalls. Each stalled cycle adds 1.
- Under stall, `m_data`, `m_valid`, `m_last` and `m_source` hold stable until `m_ready` = 1.
- Under stall, no beat is lost or duplicated.
- Throughput: 1 beat/cycle. Switching between packets costs no idle cycle, since IDLE grants and accepts in the same cycle.
- Reset (`reset` = 0 at an edge):
  - State returns to IDLE and `last_grant` = 1, so source 0 wins the first tie.
  - All shadow stages clear.
  - On the next cycle `m_valid` = 0, `m_last` = 0 and `m_source` = 0.
  - While reset is asserted, `s0_ready` = `s1_ready` = 0, and `pipe_in_*` = 0.
  - A packet in flight when reset hits is discarded; its source must restart it.
- Simultaneous events:
  - A last beat accepted while the other source is valid: the other source is granted in the next cycle (IDLE path).
  - `m_ready` rising while the tail is valid: the pipeline advances in that same cycle.

## Structure
- Shared package `processor_pkg` holds:
  - state encoding (IDLE = 0, BUSY0 = 1, BUSY1 = 2);
  - source ID constants SRC0 = 0, SRC1 = 1;
  - the default DATA_WIDTH and PIPE_DEPTH.
- One sub-module, `processor_valid_shadow`: a parameterised PIPE_DEPTH × 3-bit shift register with enable and synchronous clear.
- Arbiter FSM and stall logic live in the top module.

## Test plan
All scenarios use the 3-stage add-3 example pipeline as the shared pipeline (each beat gains +3).
- **Single packet:** s0 sends 0x10, 0x11, 0x12 (last on 0x12), `m_ready` held 1 → `m_data` = 0x13, 0x14, 0x15 in cycles t+3..t+5; `m_source` = 0; `m_last` only on 0x15.
- **Tie after reset:** s0 and s1 both present 2-beat packets → s0 packet fully first, then s1 back-to-back; `m_source` = 0, 0, 1, 1; no interleave.
- **Sink backpressure:** `m_ready` = 0 for 4 cycles while `m_valid` = 1 → `pipe_enable` = 0, both readys 0, `m_data` held; the full sequence arrives afterwards without loss or duplication.
- **Bubbles:** s0 packet with one idle cycle between beats → `m_valid` = 0 in the matching output cycle even though `pipe_out_valid` = 1.
- **Fairness:** both sources continuously offer 1-beat packets → grants alternate 0, 1, 0, 1.
- **Reset mid-packet:** `reset` = 0 during BUSY1 → next cycle state is IDLE, `m_valid` = 0 and readys are 0; after release, a tie goes to s0.
